uart_host_if: RTL
=================

# uart_host_if

Host-side byte bridge for the on-board UART. It buffers host writes in a TX FIFO and feeds the UART's `transmit`/`tx_byte` handshake one byte at a time. It drains the UART's `data_ready`/`data_read` receive handshake into an RX FIFO. It sits between the UART instance and the bus/CPU register logic, shares the UART's clock and reset, and gives the host flow-controlled byte streams in both directions.

## Interface
- `DEPTH_LOG2`, 4: log2 of each FIFO's depth (16 entries per direction).
- `clk` in 1: master clock, same clock as the UART.
- `rst` in 1: synchronous, active-high reset, same net as the UART's `rst`.
- `wr_en` in 1: host push of `wr_data` into the TX FIFO.
- `wr_data` in 8: byte to transmit.
- `tx_full` out 1: TX FIFO full.
- `tx_empty` out 1: TX FIFO empty and no byte in flight.
- `tx_overflow` out 1: sticky; set when `wr_en` is dropped while the FIFO is full.
- `rd_en` in 1: host pop from the RX FIFO.
- `rd_data` out 8: RX FIFO head, first-word fall-through.
- `rx_avail` out 1: RX FIFO not empty.
- `rx_overflow` out 1: sticky; set when a received byte is dropped because the RX FIFO is full.
- `ovf_clr` in 1: clears both sticky overflow flags.
- `rx_err_count` out 8: saturating count of `u_recv_error` pulses.
- `u_transmit` out 1: to UART `transmit`.
- `u_tx_byte` out 8: to UART `tx_byte`.
- `u_is_transmitting` in 1: from UART `is_transmitting`.
- `u_data_ready` in 1: from UART `data_ready`, a level signal.
- `u_rx_byte` in 8: from UART `rx_byte`.
- `u_data_read` out 1: to UART `data_read`.
- `u_recv_error` in 1: from UART `recv_error`, a one-cycle pulse.

## Operation
- **Reset values:** all outputs are 0, except `tx_empty` = 1. `rd_data` is 0. Both FIFOs are emptied, both FSMs return to IDLE, and `rx_err_count` is cleared.
- **TX FSM states:** TX_IDLE, TX_START, TX_BUSY.
  - TX_IDLE: when the TX FIFO is not empty and `u_is_transmitting` = 0, pop the head into the `u_tx_byte` register and go to TX_START.
  - TX_START: hold `u_transmit` = 1 until `u_is_transmitting` is sampled 1, then drop `u_transmit` and go to TX_BUSY.
  - TX_BUSY: wait for `u_is_transmitting` = 0, then go to TX_IDLE.
  - `u_tx_byte` is stable from TX_START through TX_BUSY.
- **RX FSM states:** RX_IDLE, RX_ACK.
  - RX_IDLE: when `u_data_ready` = 1, sample `u_rx_byte` and `u_recv_error` together.
    - `u_recv_error` = 1: discard the byte.
    - `u_recv_error` = 0 and RX FIFO not full: push the byte.
    - `u_recv_error` = 0 and RX FIFO full: drop the byte and set `rx_overflow`.
    - In every case, assert `u_data_read` for exactly one cycle and go to RX_ACK.
  - RX_ACK: wait for `u_data_ready` = 0, then go to RX_IDLE. This prevents a double capture.
- **Error counter:** `rx_err_count` increments on every cycle with `u_recv_error` = 1, including start-bit glitches with no `data_ready`. It saturates at 255.
- **FIFOs:**
  - Push and pop in the same cycle on a full FIFO both take effect; the count is unchanged.
  - Pop on an empty FIFO is ignored and `rd_data` holds its value.
  - Pointers are `DEPTH_LOG2` bits and wrap modulo depth. The count is `DEPTH_LOG2`+1 bits.
- **Overflow flags:**
  - If `ovf_clr` and a new overflow event occur in the same cycle, the set wins.
  - `tx_overflow` is set only for `wr_en` while full with no same-cycle pop.

## Timing
- Write to an idle TX path: `wr_en` in cycle N, FIFO non-empty at N+1, `u_transmit` = 1 from N+2.
- `u_transmit` stays high at least 1 cycle and is high at most until the cycle after `u_is_transmitting` rises.
- Back-to-back bytes: the next `u_transmit` asserts no earlier than 1 cycle after `u_is_transmitting` falls.
- RX: `u_data_ready` rises in cycle M. The byte is visible on `rd_data`/`rx_avail` at M+2, and `u_data_read` = 1 in cycle M+1.
- `rd_en` takes effect at the clock edge; the next head is on `rd_data` in the following cycle.
- A reset mid-transfer aborts silently. The UART resets on the same edge, so the in-flight byte is lost and this is not flagged.

## Structure
- Package `uart_host_pkg`: TX/RX state encodings and the `DEPTH_LOG2` default.
- Sub-module `byte_fifo`: synchronous FWFT FIFO, 8-bit, parameterised by `DEPTH_LOG2`, with `full`/`empty` outputs. It is instantiated twice.

## Test plan
- **Single TX byte:** write 0x55 to an idle UART. Expect `u_transmit` at +2 cycles, `u_tx_byte` = 0x55 until `u_is_transmitting` falls, then `tx_empty` = 1.
- **TX burst and overflow:** write 17 bytes 0x00..0x10 with the UART held busy. Expect `tx_full` after the 16th write, `tx_overflow` = 1, and 0x10 never sent. Released bytes go out in order 0x00..0x0F.
- **RX good byte:** model `u_data_ready` high with `u_rx_byte` = 0xA3. Expect one `u_data_read` pulse, then `rx_avail` = 1 and `rd_data` = 0xA3. `rd_en` then gives `rx_avail` = 0.
- **RX framing error:** `u_data_ready` and `u_recv_error` both rise together with byte 0x7E. Expect the byte discarded, `rx_err_count` = 1, and `u_data_read` still pulsed once.
- **RX full:** 17 good bytes with no reads. Expect `rx_overflow` = 1 and the FIFO holding the first 16 bytes. `ovf_clr` clears the flag. Simultaneous `rd_en` and capture while full keeps the count at 16.
- **Reset mid-TX:** assert `rst` during TX_BUSY with 3 bytes queued. Expect `tx_empty` = 1, `u_transmit` = 0, and no further transmissions.

Source files
------------

// File: rtl/uart_host_pkg.sv
// rtl/uart_host_pkg.sv - shared state encodings and defaults for the UART host bridge
package uart_host_pkg;

    localparam int DEPTH_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_BUSY  = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous first-word fall-through byte FIFO
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write request and byte
//   pop             : read request, ignored when empty
//   head            : current head byte, valid whenever empty = 0
//   full, empty     : occupancy flags
module byte_fifo
    import uart_host_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full FIFO is still accepted when the same cycle pops,
    // so the slot freed by the pop is reused and the count stays put.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count == '0);
    // Memory is reset so the head reads 0 out of reset and never exposes X.
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_host_if.sv
// rtl/uart_host_if.sv - host byte bridge between bus logic and the UART handshakes
//   host TX   : wr_en, wr_data, tx_full, tx_empty, tx_overflow
//   host RX   : rd_en, rd_data, rx_avail, rx_overflow, rx_err_count
//   control   : clk, rst (sync active-high), ovf_clr
//   UART side : u_transmit, u_tx_byte, u_is_transmitting,
//               u_data_ready, u_rx_byte, u_data_read, u_recv_error
module uart_host_if
    import uart_host_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_overflow,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rx_avail,
    output logic       rx_overflow,
    input  logic       ovf_clr,
    output logic [7:0] rx_err_count,
    output logic       u_transmit,
    output logic [7:0] u_tx_byte,
    input  logic       u_is_transmitting,
    input  logic       u_data_ready,
    input  logic [7:0] u_rx_byte,
    output logic       u_data_read,
    input  logic       u_recv_error
);

    tx_state_t  tx_state;
    rx_state_t  rx_state;

    logic [7:0] tx_head;
    logic       tx_fifo_full;
    logic       tx_fifo_empty;
    logic       tx_pop;

    logic       rx_fifo_full;
    logic       rx_fifo_empty;
    logic       cap_valid;
    logic [7:0] cap_byte;

    assign tx_pop   = (tx_state == TX_IDLE) && !tx_fifo_empty && !u_is_transmitting;
    assign tx_full  = tx_fifo_full;
    assign tx_empty = tx_fifo_empty && (tx_state == TX_IDLE);
    assign rx_avail = !rx_fifo_empty;

    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_fifo_full),
        .empty     (tx_fifo_empty)
    );

    // The captured byte is pushed one cycle after sampling, so it reaches
    // rd_data two cycles after data_ready rises.
    byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_valid),
        .push_data (cap_byte),
        .pop       (rd_en),
        .head      (rd_data),
        .full      (rx_fifo_full),
        .empty     (rx_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            u_transmit <= 1'b0;
            u_tx_byte  <= 8'h00;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        u_tx_byte  <= tx_head;
                        u_transmit <= 1'b1;
                        tx_state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (u_is_transmitting) begin
                        u_transmit <= 1'b0;
                        tx_state   <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (!u_is_transmitting) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    u_transmit <= 1'b0;
                    tx_state   <= TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            u_data_read <= 1'b0;
            cap_valid   <= 1'b0;
            cap_byte    <= 8'h00;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (u_data_ready) begin
                        cap_valid   <= !u_recv_error;
                        cap_byte    <= u_rx_byte;
                        u_data_read <= 1'b1;
                        rx_state    <= RX_ACK;
                    end else begin
                        cap_valid   <= 1'b0;
                        u_data_read <= 1'b0;
                    end
                end
                RX_ACK: begin
                    cap_valid   <= 1'b0;
                    u_data_read <= 1'b0;
                    // data_ready is a level; wait for it to drop so the
                    // same byte is not captured twice.
                    if (!u_data_ready) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    cap_valid   <= 1'b0;
                    u_data_read <= 1'b0;
                    rx_state    <= RX_IDLE;
                end
            endcase
        end
    end

    // Overflow flags: a new event in the same cycle as ovf_clr wins.
    // RX overflow is judged at push time so a coincident host pop frees room.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow  <= 1'b0;
            rx_overflow  <= 1'b0;
            rx_err_count <= 8'h00;
        end else begin
            if (wr_en && tx_fifo_full && !tx_pop) begin
                tx_overflow <= 1'b1;
            end else if (ovf_clr) begin
                tx_overflow <= 1'b0;
            end
            if (cap_valid && rx_fifo_full && !rd_en) begin
                rx_overflow <= 1'b1;
            end else if (ovf_clr) begin
                rx_overflow <= 1'b0;
            end
            if (u_recv_error && (rx_err_count != 8'hFF)) begin
                rx_err_count <= rx_err_count + 8'd1;
            end
        end
    end

endmodule
